pixel_hit_merger: RTL

- Downstream consumer of the column priority readout.
- Takes the two hit streams (up half: pixels 90..179; down half: pixels 0..89), each a 15-bit word {pixel index[14:8], time stamp[7:0]}.
- Buffers each stream in its own FIFO, round-robin merges them into one tagged 18-bit stream with valid/ready handshake, and appends a per-frame trailer word carrying the hit count.

---
 rtl/pixel_hit_merger.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pixel_hit_merger.sv
// Merges the up/down column hit streams into one tagged 18-bit stream and
// closes every frame with a trailer word carrying the frame's hit count.

module phm_fifo #(
  parameter int DEPTH       = 8,
  parameter int HOLD_MARGIN = 2
) (
  input  logic        sys_clock,
  input  logic        sys_resetn,
  input  logic        wr_i,
  input  logic [14:0] wdata_i,
  input  logic        rd_i,
  output logic [14:0] rdata_o,
  output logic        empty_o,
  output logic        hold_o,
  output logic        drop_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [14:0]   mem_q [DEPTH];
  logic          full, wr_ok;

  // a read in the same cycle frees the slot, so a full FIFO still accepts
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign wr_ok   = wr_i && (!full || rd_i);
  assign drop_o  = wr_i && !wr_ok;
  assign empty_o = (cnt_q == '0);
  assign hold_o  = (cnt_q >= (AW+1)'(DEPTH - HOLD_MARGIN));
  assign rdata_o = mem_q[rptr_q];

  always_comb cnt_d = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_i);

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (rd_i)  rptr_q <= rptr_q + AW'(1);
    end
  end

  always_ff @(posedge sys_clock) begin
    if (wr_ok) mem_q[wptr_q] <= wdata_i;
  end
endmodule

module pixel_hit_merger #(
  parameter int DEPTH       = 8,
  parameter int HOLD_MARGIN = 2
) (
  input  logic        sys_clock,
  input  logic        sys_resetn,
  input  logic        up_valid_i,
  input  logic [14:0] up_addr_i,
  input  logic        down_valid_i,
  input  logic [14:0] down_addr_i,
  input  logic        frame_end_i,
  output logic        up_hold_o,
  output logic        down_hold_o,
  output logic [17:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [7:0]  ovf_cnt_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_TRAILER} state_t;

  state_t      state_q, state_d;
  logic [17:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic [14:0] fcnt_q, fcnt_d;
  logic [7:0]  ovf_q, ovf_d;
  logic        last_up_q, last_up_d;
  logic        pend_q, pend_d;

  logic [14:0] up_rdata, dn_rdata;
  logic        up_empty, dn_empty, up_drop, dn_drop;
  logic        load, can_merge, grant_up, grant_dn, trailer_go;
  logic [8:0]  ovf_sum;

  phm_fifo #(.DEPTH(DEPTH), .HOLD_MARGIN(HOLD_MARGIN)) u_up (
    .sys_clock(sys_clock), .sys_resetn(sys_resetn),
    .wr_i(up_valid_i), .wdata_i(up_addr_i), .rd_i(grant_up),
    .rdata_o(up_rdata), .empty_o(up_empty), .hold_o(up_hold_o), .drop_o(up_drop)
  );

  phm_fifo #(.DEPTH(DEPTH), .HOLD_MARGIN(HOLD_MARGIN)) u_dn (
    .sys_clock(sys_clock), .sys_resetn(sys_resetn),
    .wr_i(down_valid_i), .wdata_i(down_addr_i), .rd_i(grant_dn),
    .rdata_o(dn_rdata), .empty_o(dn_empty), .hold_o(down_hold_o), .drop_o(dn_drop)
  );

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fcnt_q    <= '0;
      ovf_q     <= '0;
      last_up_q <= 1'b1;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fcnt_q    <= fcnt_d;
      ovf_q     <= ovf_d;
      last_up_q <= last_up_d;
      pend_q    <= pend_d;
    end
  end

  // Output process: arbitration, output register load, trailer insertion
  always_comb begin
    load       = !valid_q || ready_i;
    can_merge  = (state_q != S_TRAILER) && load;
    grant_up   = can_merge && !up_empty && (dn_empty || !last_up_q);
    grant_dn   = can_merge && !dn_empty && !grant_up;
    trailer_go = (state_q == S_FLUSH) && load && up_empty && dn_empty;
    data_d     = data_q;
    valid_d    = valid_q;
    last_up_d  = last_up_q;
    fcnt_d     = fcnt_q;
    if (state_q == S_TRAILER) begin
      if (ready_i) valid_d = 1'b0;
    end else if (load) begin
      valid_d = grant_up || grant_dn || trailer_go;
      if (grant_up)        data_d = {3'b010, up_rdata};
      else if (grant_dn)   data_d = {3'b000, dn_rdata};
      else if (trailer_go) data_d = {3'b100, fcnt_q};
    end
    if (grant_up || grant_dn) last_up_d = grant_up;
    if (trailer_go)                                 fcnt_d = '0;
    else if ((grant_up || grant_dn) && fcnt_q != '1) fcnt_d = fcnt_q + 15'd1;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_end_i) state_d = S_FLUSH;
        else if (up_valid_i || down_valid_i || !up_empty || !dn_empty) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (frame_end_i) state_d = S_FLUSH;
        else if (up_empty && dn_empty && !up_valid_i && !down_valid_i && !valid_d)
          state_d = S_IDLE;
      end
      S_FLUSH: if (trailer_go) state_d = S_TRAILER;
      S_TRAILER: begin
        if (ready_i) begin
          if (pend_q || frame_end_i)     state_d = S_FLUSH;
          else if (!up_empty || !dn_empty) state_d = S_STREAM;
          else                            state_d = S_IDLE;
        end else begin
          pend_d = pend_q || frame_end_i;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ovf_sum = 9'(ovf_q) + 9'(up_drop) + 9'(dn_drop);
    ovf_d   = (ovf_sum > 9'd255) ? 8'd255 : ovf_sum[7:0];
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign ovf_cnt_o = ovf_q;
  assign busy_o    = (state_q != S_IDLE) || valid_q;
endmodule
